enemy_swarm: RTL and testbench
==============================

Name: enemy_swarm

Overview:
- Parametrised multi-enemy position controller for the dot-matrix shooter; successor to the single-enemy mover.
- Drives N_ENEMY enemies on a GRID_ROWS x GRID_COLS field: random vertical jitter, periodic advance toward the player column, hit detection and timed respawn.
- Runs entirely on clk with an internal tick enable (no derived clock). Feeds the display scanner and the score logic.

Parameters:
N_ENEMY, 4, number of enemies (1..32)
GRID_ROWS, 8, field rows; legal enemy rows are 1..GRID_ROWS-2
GRID_COLS, 8, field columns; enemies spawn at column 0
POS_W, 3, width of each row/column coordinate (must cover GRID_ROWS-1 and GRID_COLS-1)
TICK_DIV, 12500000, clk cycles per movement tick
DESCEND_EVERY, 4, ticks between column advances
RESPAWN_DELAY, 3, ticks a killed enemy stays dead
SEED, 32'h1, LFSR reset value (0 is replaced by 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
enable  in  1  1 = movement ticks run; 0 = divider and moves frozen
hit_valid  in  1  shot present this cycle at (hit_row, hit_col)
hit_row  in  POS_W  shot row
hit_col  in  POS_W  shot column
enemy_row  out  N_ENEMY*POS_W  row of enemy i at bits [i*POS_W +: POS_W]
enemy_col  out  N_ENEMY*POS_W  column of enemy i, same packing
enemy_alive  out  N_ENEMY  1 = enemy i drawn and hittable
tick  out  1  one-cycle pulse on each movement tick
kill_pulse  out  N_ENEMY  one-cycle pulse: enemy i killed by a shot
breach  out  N_ENEMY  one-cycle pulse: enemy i reached column GRID_COLS-1
kill_count  out  8  total kills, saturating at 255

Behaviour:
- Reset (rst=0 at a clk edge):
  - divider = 0; descend counter = 0; LFSR = SEED (1 if SEED = 0).
  - enemy i: row = 1 + (i mod (GRID_ROWS-2)), col = 0, alive = 1, respawn timer = 0.
  - tick, kill_pulse, breach = 0; kill_count = 0.
  - Reset overrides everything, including reset asserted mid-operation.
- Divider:
  - Counts 0..TICK_DIV-1 only while enable = 1; holds its value when enable = 0.
  - tick is registered and equals 1 for exactly the cycle after the divider reaches TICK_DIV-1; the divider wraps to 0.
  - All tick actions below happen on the clk edge that ends the tick = 1 cycle.
- LFSR:
  - 32-bit Galois, polynomial mask 32'h80200003; shift right, XOR the mask when the LSB is 1.
  - Advances once per tick. All decisions in a tick use the pre-advance value L.
- Per tick, for each alive enemy i that is not hit this cycle:
  - Direction: L[i] = 0 means down (row+1); L[i] = 1 means up (row-1).
  - Bounce: down at row GRID_ROWS-2 becomes up; up at row 1 becomes down.
  - Descend counter increments and wraps at DESCEND_EVERY-1. On wrap, col also increments.
  - If the new col equals GRID_COLS-1: breach[i] pulses, alive = 0, timer = RESPAWN_DELAY, and the position is left at the breach cell.
- Dead enemies:
  - Each tick, the timer decrements.
  - On the tick where the timer is already 1: alive = 1, col = 0, row = 1 + (L[7:0] mod (GRID_ROWS-2)).
  - A dead enemy never moves and cannot be hit.
- Hits:
  - Evaluated every clk cycle, independent of enable or tick.
  - Any alive enemy whose current registered (row, col) equals (hit_row, hit_col) while hit_valid = 1 is killed.
  - On a kill: alive = 0 at the next edge, kill_pulse[i] = 1 for one cycle, timer = RESPAWN_DELAY.
  - Overlapping enemies on the same cell all die.
  - kill_count += popcount(kills), saturating at 255.
- Simultaneous hit and tick: the hit is compared against the pre-move position. The hit wins: the enemy dies, does not move, and no breach is reported.
- Dead-enemy countdown has no interaction with hits.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. TICK_DIV=4, DESCEND_EVERY=2, N_ENEMY=2, rst low 2 cycles then high, enable=1 -> rows 1,2, cols 0,0, alive=2'b11; tick pulses every 4th cycle; rows change by ±1 per tick; cols reach 1 after 2 ticks.
2. Force enemy 0 to row 1 with L[0]=1 (seeded) -> next row 2 (bounce). Force enemy 0 to row 6 with direction down -> next row 5. Row never leaves 1..6.
3. hit_valid at enemy 1's cell, same cycle as tick -> kill_pulse=2'b10, alive[1]=0, enemy 1 position unchanged, kill_count=1. RESPAWN_DELAY=3 -> alive[1]=1 on the 3rd later tick at col 0, row in 1..6.
4. Run until enemy 0 advances to col 7 -> breach[0] one-cycle pulse, alive[0]=0, kill_count unchanged, respawn after RESPAWN_DELAY ticks.
5. enable=0 for 20 cycles -> no tick, positions frozen. A hit during this window still kills. Re-enable -> divider resumes from its held value.
6. Two enemies on the same cell, hit there, kill_count preloaded to 254 -> both kill_pulse bits set, kill_count=255. A further kill leaves 255. rst=0 mid-run -> all state returns to reset values next edge.

Source files
------------

// File: rtl/enemy_swarm.sv
// Multi-enemy position controller: LFSR jitter, periodic column advance,
// shot detection and timed respawn, all on clk with an internal tick enable.
module enemy_swarm #(
  parameter int          N_ENEMY       = 4,
  parameter int          GRID_ROWS     = 8,
  parameter int          GRID_COLS     = 8,
  parameter int          POS_W         = 3,
  parameter int          TICK_DIV      = 12500000,
  parameter int          DESCEND_EVERY = 4,
  parameter int          RESPAWN_DELAY = 3,
  parameter logic [31:0] SEED          = 32'h1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       hit_valid,
  input  logic [POS_W-1:0]           hit_row,
  input  logic [POS_W-1:0]           hit_col,
  output logic [N_ENEMY*POS_W-1:0]   enemy_row,
  output logic [N_ENEMY*POS_W-1:0]   enemy_col,
  output logic [N_ENEMY-1:0]         enemy_alive,
  output logic                       tick,
  output logic [N_ENEMY-1:0]         kill_pulse,
  output logic [N_ENEMY-1:0]         breach,
  output logic [7:0]                 kill_count
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DSC_W = (DESCEND_EVERY > 1) ? $clog2(DESCEND_EVERY) : 1;
  localparam int TMR_W = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY + 1) : 1;
  localparam logic [31:0]      LFSR_MASK = 32'h80200003;
  localparam logic [31:0]      LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] ROW_MAX   = POS_W'(GRID_ROWS - 2);
  localparam logic [POS_W-1:0] COL_LAST  = POS_W'(GRID_COLS - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(RESPAWN_DELAY);

  logic [DIV_W-1:0]         r_div;
  logic [DSC_W-1:0]         r_desc;
  logic [31:0]              r_lfsr;
  logic [N_ENEMY*POS_W-1:0] r_row;
  logic [N_ENEMY*POS_W-1:0] r_col;
  logic [N_ENEMY-1:0]       r_alive;
  logic [N_ENEMY*TMR_W-1:0] r_timer;
  logic                     r_tick;
  logic [N_ENEMY-1:0]       r_kill;
  logic [N_ENEMY-1:0]       r_breach;
  logic [7:0]               r_killCount;

  logic                     w_descWrap;
  logic [31:0]              w_lfsrNext;
  logic [POS_W-1:0]         w_spawnRow;
  logic [N_ENEMY*POS_W-1:0] w_rowNext;
  logic [N_ENEMY*POS_W-1:0] w_colNext;
  logic [N_ENEMY-1:0]       w_aliveNext;
  logic [N_ENEMY*TMR_W-1:0] w_timerNext;
  logic [N_ENEMY-1:0]       w_kill;
  logic [N_ENEMY-1:0]       w_breach;
  logic [POS_W-1:0]         w_curRow;
  logic [POS_W-1:0]         w_curCol;
  logic [POS_W-1:0]         w_newCol;
  logic [TMR_W-1:0]         w_curTimer;
  logic                     w_goUp;
  logic [8:0]               w_killSum;
  logic [7:0]               w_killCountNext;

  assign w_descWrap = (r_desc == DSC_W'(DESCEND_EVERY - 1));
  assign w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);
  assign w_spawnRow = POS_W'(32'd1 + (32'(r_lfsr[7:0]) % 32'(GRID_ROWS - 2)));

  // A shot is checked against the pre-move position and always beats a tick move.
  always_comb begin
    w_rowNext   = r_row;
    w_colNext   = r_col;
    w_aliveNext = r_alive;
    w_timerNext = r_timer;
    w_kill      = '0;
    w_breach    = '0;
    w_curRow    = '0;
    w_curCol    = '0;
    w_newCol    = '0;
    w_curTimer  = '0;
    w_goUp      = 1'b0;
    for (int i = 0; i < N_ENEMY; i++) begin
      w_curRow   = r_row[i*POS_W +: POS_W];
      w_curCol   = r_col[i*POS_W +: POS_W];
      w_curTimer = r_timer[i*TMR_W +: TMR_W];
      if (hit_valid && r_alive[i] && (w_curRow == hit_row) && (w_curCol == hit_col)) begin
        w_kill[i]                        = 1'b1;
        w_aliveNext[i]                   = 1'b0;
        w_timerNext[i*TMR_W +: TMR_W]    = TMR_LOAD;
      end else if (r_tick) begin
        if (r_alive[i]) begin
          w_goUp = r_lfsr[i];
          if (w_goUp && (w_curRow <= POS_ONE)) begin
            w_goUp = 1'b0;
          end else if (!w_goUp && (w_curRow >= ROW_MAX)) begin
            w_goUp = 1'b1;
          end
          w_rowNext[i*POS_W +: POS_W] = w_goUp ? (w_curRow - POS_ONE) : (w_curRow + POS_ONE);
          w_newCol = w_descWrap ? (w_curCol + POS_ONE) : w_curCol;
          w_colNext[i*POS_W +: POS_W] = w_newCol;
          if (w_newCol == COL_LAST) begin
            w_breach[i]                   = 1'b1;
            w_aliveNext[i]                = 1'b0;
            w_timerNext[i*TMR_W +: TMR_W] = TMR_LOAD;
          end
        end else if (w_curTimer <= TMR_ONE) begin
          w_aliveNext[i]                = 1'b1;
          w_colNext[i*POS_W +: POS_W]   = '0;
          w_rowNext[i*POS_W +: POS_W]   = w_spawnRow;
          w_timerNext[i*TMR_W +: TMR_W] = '0;
        end else begin
          w_timerNext[i*TMR_W +: TMR_W] = w_curTimer - TMR_ONE;
        end
      end
    end
  end

  always_comb begin
    w_killSum = {1'b0, r_killCount};
    for (int i = 0; i < N_ENEMY; i++) begin
      w_killSum = w_killSum + 9'(w_kill[i]);
    end
    w_killCountNext = (w_killSum > 9'd255) ? 8'hFF : w_killSum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div       <= '0;
      r_desc      <= '0;
      r_lfsr      <= LFSR_INIT;
      r_col       <= '0;
      r_alive     <= '1;
      r_timer     <= '0;
      r_tick      <= 1'b0;
      r_kill      <= '0;
      r_breach    <= '0;
      r_killCount <= '0;
      for (int i = 0; i < N_ENEMY; i++) begin
        r_row[i*POS_W +: POS_W] <= POS_W'(1 + (i % (GRID_ROWS - 2)));
      end
    end else begin
      r_tick <= 1'b0;
      if (enable) begin
        if (r_div == DIV_W'(TICK_DIV - 1)) begin
          r_div  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
      if (r_tick) begin
        r_lfsr <= w_lfsrNext;
        r_desc <= w_descWrap ? '0 : (r_desc + DSC_W'(1));
      end
      r_row       <= w_rowNext;
      r_col       <= w_colNext;
      r_alive     <= w_aliveNext;
      r_timer     <= w_timerNext;
      r_kill      <= w_kill;
      r_breach    <= w_breach;
      r_killCount <= w_killCountNext;
    end
  end

  assign enemy_row   = r_row;
  assign enemy_col   = r_col;
  assign enemy_alive = r_alive;
  assign tick        = r_tick;
  assign kill_pulse  = r_kill;
  assign breach      = r_breach;
  assign kill_count  = r_killCount;

endmodule

// File: tb/tb_enemy_swarm.sv
// Directed bench for enemy_swarm: two enemies, fast tick, seed 1; expected
// positions follow the LFSR sequence worked out by hand.
module tb_enemy_swarm;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       hit_valid;
  logic [2:0] hit_row;
  logic [2:0] hit_col;
  logic [5:0] enemy_row;
  logic [5:0] enemy_col;
  logic [1:0] enemy_alive;
  logic       tick;
  logic [1:0] kill_pulse;
  logic [1:0] breach;
  logic [7:0] kill_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enemy_swarm #(
    .N_ENEMY(2), .GRID_ROWS(8), .GRID_COLS(8), .POS_W(3),
    .TICK_DIV(4), .DESCEND_EVERY(2), .RESPAWN_DELAY(3), .SEED(32'h1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .enemy_row(enemy_row), .enemy_col(enemy_col), .enemy_alive(enemy_alive),
    .tick(tick), .kill_pulse(kill_pulse), .breach(breach), .kill_count(kill_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic hv, input logic [2:0] r, input logic [2:0] c);
    hit_valid = hv;
    hit_row   = r;
    hit_col   = c;
  endtask

  // Packed expectations: value = enemy1 * 8 + enemy0.
  task automatic checkPos(input string tag, input int rows, input int cols, input int alive);
    checkOutput({tag, "_row"}, 32'(enemy_row), rows);
    checkOutput({tag, "_col"}, 32'(enemy_col), cols);
    checkOutput({tag, "_alive"}, 32'(enemy_alive), alive);
  endtask

  task automatic waitTick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 16 && !seen; c++) begin
      step();
      seen = tick;
    end
    checkOutput({tag, "_tickSeen"}, 32'(seen), 1);
  endtask

  // Wait for a tick, then step over its action edge.
  task automatic doTick(input string tag);
    waitTick(tag);
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    int tickCnt;
    int expKc;
    rst    = 1'b0;
    enable = 1'b1;
    applyStimulus(1'b0, 3'd0, 3'd0);
    step();
    step();
    checkPos("reset", 17, 0, 3);
    checkOutput("reset_tick", 32'(tick), 0);
    checkOutput("reset_kc", 32'(kill_count), 0);
    checkOutput("reset_kill", 32'(kill_pulse), 0);
    checkOutput("reset_breach", 32'(breach), 0);
    rst = 1'b1;

    for (int c = 1; c <= 4; c++) begin
      step();
      checkOutput($sformatf("tickPeriod%0d", c), 32'(tick), (c == 4) ? 1 : 0);
    end
    step();
    checkPos("t1", 26, 0, 3);
    checkOutput("t1_tickLow", 32'(tick), 0);
    doTick("t2");  checkPos("t2", 17, 9, 3);
    doTick("t3");  checkPos("t3", 10, 9, 3);
    doTick("t4");  checkPos("t4", 17, 18, 3);

    // Shot on enemy 1 during the tick cycle: it dies in place.
    waitTick("t5");
    applyStimulus(1'b1, 3'd2, 3'd2);
    step();
    applyStimulus(1'b0, 3'd0, 3'd0);
    checkPos("t5hit", 18, 18, 1);
    checkOutput("t5_kill", 32'(kill_pulse), 2);
    checkOutput("t5_kc", 32'(kill_count), 1);
    checkOutput("t5_breach", 32'(breach), 0);
    step();
    checkOutput("t5_killOnce", 32'(kill_pulse), 0);
    doTick("t6");  checkPos("t6", 19, 19, 1);
    doTick("t7");  checkPos("t7", 18, 19, 1);
    doTick("t8");  checkPos("t8", 33, 4, 3);
    doTick("t9");  checkPos("t9", 26, 4, 3);

    // Frozen window; a shot still lands.
    enable  = 1'b0;
    tickCnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) applyStimulus(1'b1, 3'd3, 3'd0);
      step();
      if (c == 10) begin
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkOutput("freeze_kill", 32'(kill_pulse), 2);
        checkOutput("freeze_kc", 32'(kill_count), 2);
      end
      if (tick) tickCnt++;
    end
    checkOutput("freeze_noTick", 32'(tickCnt), 0);
    checkPos("freeze", 26, 4, 1);
    enable = 1'b1;
    step();  checkOutput("resume1", 32'(tick), 0);
    step();  checkOutput("resume2", 32'(tick), 0);
    step();  checkOutput("resume3", 32'(tick), 1);
    step();
    checkPos("t10", 25, 5, 1);
    doTick("t11"); checkPos("t11", 26, 5, 1);
    doTick("t12"); checkPos("t12", 27, 6, 3);
    doTick("t13"); checkPos("t13", 34, 6, 3);
    doTick("t14"); checkPos("t14", 25, 15, 2);
    checkOutput("t14_breach", 32'(breach), 1);
    checkOutput("t14_kc", 32'(kill_count), 2);
    checkOutput("t14_kill", 32'(kill_pulse), 0);
    step();
    checkOutput("t14_breachOnce", 32'(breach), 0);
    doTick("t15"); checkPos("t15", 17, 15, 2);
    doTick("t16"); checkPos("t16", 25, 23, 2);
    doTick("t17"); checkPos("t17", 20, 16, 3);

    // Kill both in one tick interval so they respawn together on one cell.
    applyStimulus(1'b1, 3'd4, 3'd0);
    step();
    checkOutput("pre_kill0", 32'(kill_pulse), 1);
    checkOutput("pre_kc3", 32'(kill_count), 3);
    applyStimulus(1'b1, 3'd2, 3'd2);
    step();
    applyStimulus(1'b0, 3'd0, 3'd0);
    checkOutput("pre_kill1", 32'(kill_pulse), 2);
    checkOutput("pre_kc4", 32'(kill_count), 4);

    expKc = 4;
    for (int r = 0; r < 127; r++) begin
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        step();
        seen = (enemy_alive == 2'b11);
      end
      checkOutput("respawnPair", 32'(seen), 1);
      applyStimulus(1'b1, enemy_row[2:0], enemy_col[2:0]);
      step();
      applyStimulus(1'b0, 3'd0, 3'd0);
      expKc = (expKc + 2 > 255) ? 255 : expKc + 2;
      checkOutput("pairKill", 32'(kill_pulse), 3);
      checkOutput("killSat", 32'(kill_count), expKc);
    end
    checkOutput("final_kc", 32'(kill_count), 255);

    // Reset in the middle of activity.
    rst = 1'b0;
    applyStimulus(1'b1, 3'd1, 3'd0);
    step();
    applyStimulus(1'b0, 3'd0, 3'd0);
    checkPos("midReset", 17, 0, 3);
    checkOutput("midReset_kc", 32'(kill_count), 0);
    checkOutput("midReset_tick", 32'(tick), 0);
    checkOutput("midReset_kill", 32'(kill_pulse), 0);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
